// File: rtl/maxnet_pkg.sv
// maxnet_pkg -- shared definitions for the MAXNET result collector.
//   N      : number of activations in one feedback vector
//   IDX_W  : width of a word / activation index
//   CNT_W  : width of the positive-activation count (0..N)
//   state_e: collector FSM states
package maxnet_pkg;

   localparam int N     = 4;
   localparam int IDX_W = 2;
   localparam int CNT_W = 3;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_COLLECT  = 3'd1,
      S_EVAL     = 3'd2,
      S_FEEDBACK = 3'd3,
      S_DONE     = 3'd4
   } state_e;

endpackage

// File: rtl/maxnet_eval.sv
// maxnet_eval -- combinational evaluation of one activation vector.
// Ports:
//   vec_i     : N signed words, word k at [k*XLEN +: XLEN]
//   clamp_o   : ReLU-clamped copy of vec_i (negative words forced to 0)
//   pos_cnt_o : number of words that are strictly positive
//   win_idx_o : lowest index holding a positive word (0 if none)
//   win_val_o : value at win_idx_o (0 if none)
module maxnet_eval
   import maxnet_pkg::*;
#(
   parameter int XLEN = 5
) (
   input  logic [N*XLEN-1:0] vec_i,
   output logic [N*XLEN-1:0] clamp_o,
   output logic [CNT_W-1:0]  pos_cnt_o,
   output logic [IDX_W-1:0]  win_idx_o,
   output logic [XLEN-1:0]   win_val_o
);

   logic [XLEN-1:0] word;

   // Scanning from the top index down lets the lowest positive index
   // overwrite any higher one, giving a lowest-index priority encoder.
   always_comb begin
      clamp_o   = '0;
      pos_cnt_o = '0;
      win_idx_o = '0;
      win_val_o = '0;
      word      = '0;
      for (int k = N - 1; k >= 0; k--) begin
         word = vec_i[k*XLEN +: XLEN];
         if (!word[XLEN-1]) begin
            clamp_o[k*XLEN +: XLEN] = word;
         end
         if (!word[XLEN-1] && (word != '0)) begin
            pos_cnt_o = pos_cnt_o + CNT_W'(1);
            win_idx_o = IDX_W'(k);
            win_val_o = word;
         end
      end
   end

endmodule

// File: rtl/maxnet_collector.sv
// maxnet_collector -- gathers N PU result words, ReLU-clamps them, and either
// feeds the clamped vector back to the PU array for another round or stops
// once at most one activation is still positive (or MAX_ITER rounds ran).
// Ports:
//   clk, rst          : clock; synchronous active-low reset
//   start             : begins a run (honoured only in IDLE/DONE)
//   in_valid/in_ready/in_data : PU result word stream
//   fb_valid/fb_ready/fb_data0..3 : clamped feedback vector to the PU array
//   done, timeout     : run finished; finished because of MAX_ITER
//   winner/winner_val : surviving activation index and value (valid in DONE)
//   iter              : completed feedback handshakes in this run
//   dbg_state         : current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are 1. fb_valid and fb_data hold steady until fb_ready; in_ready is only
// raised in COLLECT, and in_valid is ignored everywhere else.
module maxnet_collector
   import maxnet_pkg::*;
#(
   parameter int XLEN     = 5,
   parameter int MAX_ITER = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            in_valid,
   input  logic [XLEN-1:0] in_data,
   output logic            in_ready,
   output logic            fb_valid,
   input  logic            fb_ready,
   output logic [XLEN-1:0] fb_data0,
   output logic [XLEN-1:0] fb_data1,
   output logic [XLEN-1:0] fb_data2,
   output logic [XLEN-1:0] fb_data3,
   output logic            done,
   output logic            timeout,
   output logic [1:0]      winner,
   output logic [XLEN-1:0] winner_val,
   output logic [3:0]      iter,
   output logic [2:0]      dbg_state
);

   localparam logic [3:0] ITER_LAST = 4'(MAX_ITER - 1);

   state_e                     state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [3:0]                 iter_q, iter_d;
   logic                       timeout_q, timeout_d;
   logic [N-1:0][XLEN-1:0]     buf_q, buf_d;

   logic [N-1:0][XLEN-1:0]     clamp_w;
   logic [CNT_W-1:0]           pos_cnt_w;
   logic [IDX_W-1:0]           win_idx_w;
   logic [XLEN-1:0]            win_val_w;

   // After EVAL the buffer already holds clamped values, so the same
   // evaluator output drives both the EVAL decision and the DONE result.
   maxnet_eval #(
      .XLEN (XLEN)
   ) u_eval (
      .vec_i     (buf_q),
      .clamp_o   (clamp_w),
      .pos_cnt_o (pos_cnt_w),
      .win_idx_o (win_idx_w),
      .win_val_o (win_val_w)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         iter_q    <= '0;
         timeout_q <= 1'b0;
         buf_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         iter_q    <= iter_d;
         timeout_q <= timeout_d;
         buf_q     <= buf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      iter_d    = iter_q;
      timeout_d = timeout_q;
      buf_d     = buf_q;
      in_ready  = 1'b0;
      fb_valid  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_COLLECT;
               idx_d     = '0;
               iter_d    = '0;
               timeout_d = 1'b0;
            end
         end
         S_COLLECT: begin
            in_ready = 1'b1;
            if (in_valid) begin
               buf_d[idx_q] = in_data;
               idx_d        = idx_q + IDX_W'(1);
               if (idx_q == IDX_W'(N - 1)) begin
                  state_d = S_EVAL;
               end
            end
         end
         S_EVAL: begin
            buf_d = clamp_w;
            // A settled vector wins over the iteration limit.
            if (pos_cnt_w <= CNT_W'(1)) begin
               state_d = S_DONE;
            end else if (iter_q == ITER_LAST) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
            end else begin
               state_d = S_FEEDBACK;
            end
         end
         S_FEEDBACK: begin
            fb_valid = 1'b1;
            if (fb_ready) begin
               iter_d  = iter_q + 4'd1;
               idx_d   = '0;
               state_d = S_COLLECT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign done       = (state_q == S_DONE);
   assign timeout    = timeout_q;
   assign iter       = iter_q;
   assign winner     = done ? win_idx_w : 2'd0;
   assign winner_val = done ? win_val_w : '0;
   assign fb_data0   = fb_valid ? buf_q[0] : '0;
   assign fb_data1   = fb_valid ? buf_q[1] : '0;
   assign fb_data2   = fb_valid ? buf_q[2] : '0;
   assign fb_data3   = fb_valid ? buf_q[3] : '0;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_maxnet_collector.sv
// tb_maxnet_collector -- self-checking bench for maxnet_collector.
module tb_maxnet_collector;
   import maxnet_pkg::*;

   localparam int XLEN = 5;
   localparam int EW   = 2 + XLEN + 4 + 1;   // {winner, winner_val, iter, timeout}

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            start = 1'b0;
   logic            in_valid = 1'b0;
   logic [XLEN-1:0] in_data = '0;
   logic            in_ready;
   logic            fb_valid;
   logic            fb_ready = 1'b0;
   logic [XLEN-1:0] fb_data0, fb_data1, fb_data2, fb_data3;
   logic            done, timeout;
   logic [1:0]      winner;
   logic [XLEN-1:0] winner_val;
   logic [3:0]      iter;
   logic [2:0]      dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   logic [EW-1:0] exp_q[$];

   typedef struct {
      logic [3:0][XLEN-1:0] d;
      logic [1:0]           w;
      logic [XLEN-1:0]      v;
   } vec_t;

   vec_t tbl[6];

   maxnet_collector #(.XLEN(XLEN), .MAX_ITER(15)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .fb_valid   (fb_valid),
      .fb_ready   (fb_ready),
      .fb_data0   (fb_data0),
      .fb_data1   (fb_data1),
      .fb_data2   (fb_data2),
      .fb_data3   (fb_data3),
      .done       (done),
      .timeout    (timeout),
      .winner     (winner),
      .winner_val (winner_val),
      .iter       (iter),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic set_vec(input int i, input int a, input int b, input int c, input int d,
                          input int w, input int v);
      tbl[i].d[0] = XLEN'(a);
      tbl[i].d[1] = XLEN'(b);
      tbl[i].d[2] = XLEN'(c);
      tbl[i].d[3] = XLEN'(d);
      tbl[i].w    = 2'(w);
      tbl[i].v    = XLEN'(v);
   endtask

   // driver tasks
   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Feeds N words, one per cycle; leaves the DUT in its EVAL cycle.
   task automatic feed4(input logic [3:0][XLEN-1:0] words, input string tag);
      for (int k = 0; k < 4; k++) begin
         check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
         in_valid = 1'b1;
         in_data  = words[k];
         tick();
      end
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic check_fb(input logic [3:0][XLEN-1:0] words, input string tag);
      check({tag, "_fb_valid"}, 32'(fb_valid), 32'd1);
      check({tag, "_fb_data"}, {12'd0, fb_data3, fb_data2, fb_data1, fb_data0},
            {12'd0, words[3], words[2], words[1], words[0]});
   endtask

   // scoreboard: pop the oldest expected result when DONE is observed
   task automatic sb_pop(input string tag);
      logic [EW-1:0] e;
      check({tag, "_done"}, 32'(done), 32'd1);
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_result"}, 32'({winner, winner_val, iter, timeout}), 32'(e));
      end
   endtask

   // One run that settles after a single EVAL.
   task automatic run_single(input logic [3:0][XLEN-1:0] d, input logic [1:0] w,
                             input logic [XLEN-1:0] v, input string tag);
      do_start();
      exp_q.push_back({w, v, 4'd0, 1'b0});
      feed4(d, tag);
      check({tag, "_eval_state"}, 32'(dbg_state), 32'(S_EVAL));
      check({tag, "_eval_done"}, 32'(done), 32'd0);
      tick();
      check({tag, "_no_fb"}, 32'(fb_valid), 32'd0);
      sb_pop(tag);
   endtask

   logic [3:0][XLEN-1:0] v_a, v_b;

   initial begin
      set_vec(0,  3,  0, -2,  0, 0,  3);
      set_vec(1, -4, -1,  0, -8, 0,  0);
      set_vec(2,  0,  0,  0, 15, 3, 15);
      set_vec(3,-16,  9, -1,  0, 1,  9);
      set_vec(4,  0,  0,-16,  0, 0,  0);
      set_vec(5,  0,  0,  7, -3, 2,  7);

      // reset state
      rst = 1'b0;
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_fb_valid", 32'(fb_valid), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_iter", 32'(iter), 32'd0);
      check("rst_winner", 32'({winner, winner_val}), 32'd0);
      check("rst_fb_data", 32'({fb_data3, fb_data2, fb_data1, fb_data0}), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(S_IDLE));
      rst = 1'b1;
      tick();
      check("idle_no_start", 32'(dbg_state), 32'(S_IDLE));

      // table-driven single-round runs (Run 1 and Run 3 among them)
      for (int i = 0; i < 6; i++) begin
         run_single(tbl[i].d, tbl[i].w, tbl[i].v, $sformatf("tbl%0d", i));
      end

      // random single-survivor runs against a small model
      for (int r = 0; r < 6; r++) begin
         int pos;
         int val;
         logic [1:0] ew;
         logic [XLEN-1:0] ev;
         pos = $urandom_range(0, 4);
         ew = '0;
         ev = '0;
         for (int k = 0; k < 4; k++) begin
            if (k == pos) begin
               val = $urandom_range(1, 15);
               ew = 2'(k);
               ev = XLEN'(val);
            end else begin
               val = -$urandom_range(0, 16);
            end
            v_a[k] = XLEN'(val);
         end
         run_single(v_a, ew, ev, $sformatf("rnd%0d", r));
      end

      // Run 2: feedback held under back-pressure, then second round settles
      v_a = {5'd1, 5'd2, 5'd7, 5'd5};
      fb_ready = 1'b0;
      do_start();
      check("r2_iter_clr", 32'(iter), 32'd0);
      feed4(v_a, "r2a");
      tick();
      check_fb(v_a, "r2_first");
      for (int c = 0; c < 3; c++) begin
         tick();
         check_fb(v_a, "r2_hold");
         check("r2_hold_in_ready", 32'(in_ready), 32'd0);
      end
      fb_ready = 1'b1;
      tick();
      fb_ready = 1'b0;
      check("r2_iter", 32'(iter), 32'd1);
      check("r2_fb_drop", 32'(fb_valid), 32'd0);
      v_b = {XLEN'(-3), XLEN'(-1), 5'd4, 5'd0};
      exp_q.push_back({2'd1, 5'd4, 4'd1, 1'b0});
      feed4(v_b, "r2b");
      tick();
      sb_pop("r2");

      // Run 4: never settles, forced out by the iteration limit
      v_a = {5'd0, 5'd0, 5'd1, 5'd1};
      fb_ready = 1'b1;
      do_start();
      exp_q.push_back({2'd0, 5'd1, 4'd14, 1'b1});
      for (int r = 0; r < 15; r++) begin
         feed4(v_a, "r4");
         tick();
         if (r < 14) begin
            check_fb(v_a, "r4_round");
            check("r4_timeout_low", 32'(timeout), 32'd0);
            tick();
         end
      end
      fb_ready = 1'b0;
      sb_pop("r4");

      // Run 5: reset during FEEDBACK aborts the run
      v_a = {5'd1, 5'd2, 5'd7, 5'd5};
      do_start();
      feed4(v_a, "r5");
      tick();
      check("r5_in_fb", 32'(fb_valid), 32'd1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("r5_fb_valid", 32'(fb_valid), 32'd0);
      check("r5_in_ready", 32'(in_ready), 32'd0);
      check("r5_state", 32'(dbg_state), 32'(S_IDLE));
      check("r5_iter", 32'(iter), 32'd0);
      run_single(tbl[0].d, tbl[0].w, tbl[0].v, "r5_rerun");

      // Run 6: in_valid ignored outside COLLECT, start ignored in COLLECT
      do_start();
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_data  = v_a[k];
         tick();
      end
      in_data = XLEN'(-16);
      check("r6_eval_in_ready", 32'(in_ready), 32'd0);
      tick();
      check_fb(v_a, "r6_fb");
      check("r6_fb_in_ready", 32'(in_ready), 32'd0);
      tick();
      check_fb(v_a, "r6_fb_hold");
      fb_ready = 1'b1;
      tick();
      fb_ready = 1'b0;
      in_valid = 1'b0;
      start = 1'b1;
      tick();
      check("r6_start_state", 32'(dbg_state), 32'(S_COLLECT));
      check("r6_start_iter", 32'(iter), 32'd1);
      v_b = {XLEN'(-1), 5'd6, 5'd0, 5'd0};
      exp_q.push_back({2'd2, 5'd6, 4'd1, 1'b0});
      feed4(v_b, "r6");
      start = 1'b0;
      tick();
      sb_pop("r6");

      check("sb_drained", 32'(exp_q.size()), 32'd0);

      // final report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
